morph_gene_sequencer: RTL
=========================

// Module: morph_gene_sequencer
// PURPOSE
//  Sequences a MorphologicProcessor through one chromosome: GENES packed 16-bit genes, one operation per gene.
//  Latches the chromosome on start, clears the processor, then issues one gene per clock with a ce strobe.
//  Signals done when the whole sequence has been applied.
//  Sits between the genetic-search control and the processor; drives all of the processor's op inputs.
// PARAMETERS
//  GENES   8   genes per chromosome (>=1); the processor OpCounterWidth must satisfy 2**OpCounterWidth > GENES
//  IDX_W   $clog2(GENES) (min 1)   localparam, gene index width
// PORTS
//  clk           in   1          clock, rising edge
//  rst           in   1          reset, asynchronous, active-high
//  start         in   1          1-cycle request to run the chromosome; honoured only in IDLE
//  abort         in   1          cancels a run in CLEAR/RUN
//  chromosome    in   GENES*16   gene g at [g*16+15 : g*16]
//  busy          out  1          high in CLEAR, RUN and DONE
//  done          out  1          1-cycle pulse on normal completion
//  proc_clr      out  1          1-cycle pulse to the processor rst; clears opCounter/imageAcc
//  proc_ce       out  1          processor ce; high only for issued genes
//  el            out  9          gene[15:7], structuring element
//  morph_op      out  3          gene[6:4]
//  morph_in_sel  out  1          gene[3]
//  logic_op      out  3          gene[2:0]
//  gene_idx      out  IDX_W      index of the gene currently presented
// BEHAVIOUR
//  - Outputs decode from registers only; no combinational input->output path.
//  - Reset: state=IDLE, gene_idx=0, shadow chromosome=0; busy=done=proc_clr=proc_ce=0; field outputs=0.
//  - IDLE: start && !abort -> latch chromosome into shadow, go CLEAR. start && abort -> stay IDLE.
//  - CLEAR (1 cycle): proc_clr=1, gene_idx=0 -> RUN. abort -> IDLE, no proc_ce.
//  - RUN: proc_ce=1 and fields = shadow[gene_idx]; gene_idx++ each cycle.
//    On gene_idx==GENES-1 -> DONE. abort -> IDLE; the abort cycle still issues its gene, nothing after it.
//  - DONE (1 cycle): done=1, proc_ce=0 -> IDLE; gene_idx returns to 0.
//  - Timing: start sampled at edge 0 -> CLEAR in cycle 1 -> genes 0..GENES-1 in cycles 2..GENES+1.
//    done is in cycle GENES+2. busy is high from cycle 1 through cycle GENES+2.
//  - Input changes: chromosome changes after the latch do not affect the run; start while busy is ignored.
//  - gene_idx never wraps inside a run; GENES=1 passes through RUN for exactly one cycle.
//  - Field outputs hold the last-issued gene outside RUN; consumers qualify them with proc_ce.
//  - Reset mid-run: immediate IDLE, all outputs to reset values; no done.
// CONFIGURATION
//  MORPH_SEQ_EARLY_STOP_EN
//  - Defined: a gene with logic_op==3'b111 (STOP_CODE) terminates the run.
//    That gene is not issued: proc_ce=0 in that cycle; state goes DONE next cycle and done pulses as normal.
//    A STOP in gene 0 gives CLEAR, one RUN cycle with no ce, then DONE.
//  - Undefined: 3'b111 has no special meaning and is issued like any other gene.
// STRUCTURE
//  - morph_seq_pkg holds:
//    - GENE_W=16 and the field offsets/widths (EL_LSB=7, MOP_LSB=4, MSEL_BIT=3, LOP_LSB=0);
//    - STOP_CODE=3'b111;
//    - state encoding IDLE/CLEAR/RUN/DONE.
//  - Sub-module morph_gene_mux: GENES-wide shadow word + index -> 16-bit gene. Purely combinational.
//  - Top: FSM, index counter, shadow register, output decode.
// TESTING
//  1 Reset/idle: assert rst mid-RUN -> all outputs 0 the same cycle, state IDLE; afterwards start works normally.
//  2 Normal run, GENES=4, gene g = {9'h1FF-g, 3'd1, 1'b0, 3'd(g)}:
//    - proc_clr in cycle 1;
//    - proc_ce in cycles 2..5, with logic_op 0,1,2,3 and gene_idx 0..3;
//    - done in cycle 6; busy in cycles 1..6.
//  3 start held high 10 cycles, GENES=4 -> exactly one run; start still high in the cycle after done starts a second run.
//  4 abort in cycle 3, GENES=4 -> proc_ce only in cycles 2..3, no done, busy low from cycle 4.
//    start and abort together in IDLE -> no run.
//  5 Chromosome changed in cycle 2 -> issued fields still match the value latched at start.
//  6 With MORPH_SEQ_EARLY_STOP_EN, gene 2 logic_op=3'b111 -> proc_ce in cycles 2..3 only, done in cycle 5.
//    Without the macro the same stimulus issues 4 genes.
//  Check against a MorphologicProcessor model: imageAcc after done equals the reference fold of the genes.

Source files
------------

// File: rtl/morph_seq_pkg.sv
// -----------------------------------------------------------------------------
// morph_seq_pkg
// Shared definitions for the morphologic gene sequencer:
//   - gene width and field layout (el[15:7], morph_op[6:4], in_sel[3], logic_op[2:0])
//   - STOP_CODE used by the optional early-stop feature (MORPH_SEQ_EARLY_STOP_EN)
//   - sequencer state encoding
//   - gene decode / stop-detect helpers
// -----------------------------------------------------------------------------
package morph_seq_pkg;

  localparam int GENE_W   = 16;
  localparam int EL_LSB   = 7;
  localparam int EL_W     = 9;
  localparam int MOP_LSB  = 4;
  localparam int MOP_W    = 3;
  localparam int MSEL_BIT = 3;
  localparam int LOP_LSB  = 0;
  localparam int LOP_W    = 3;

  localparam logic [LOP_W-1:0] STOP_CODE = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [EL_W-1:0]  el;
    logic [MOP_W-1:0] morph_op;
    logic             morph_in_sel;
    logic [LOP_W-1:0] logic_op;
  } gene_t;

  function automatic gene_t decode_gene(input logic [GENE_W-1:0] g);
    gene_t d;
    d.el           = g[EL_LSB +: EL_W];
    d.morph_op     = g[MOP_LSB +: MOP_W];
    d.morph_in_sel = g[MSEL_BIT];
    d.logic_op     = g[LOP_LSB +: LOP_W];
    return d;
  endfunction

  function automatic logic is_stop(input gene_t g);
    return (g.logic_op == STOP_CODE);
  endfunction

endpackage

// File: rtl/morph_gene_sequencer_if.sv
// -----------------------------------------------------------------------------
// morph_gene_sequencer_if
// Bundles the control/processor-facing signals of the gene sequencer.
// Names carry i_/o_ from the sequencer's point of view.
//   i_start, i_abort, i_chromosome[GENES*16]          : from genetic-search control
//   o_busy, o_done                                     : status to control
//   o_proc_clr, o_proc_ce, o_el, o_morph_op,
//   o_morph_in_sel, o_logic_op                         : processor op inputs
//   o_gene_idx[IDX_W]                                  : index of presented gene
// Modports: master (control side / bench), slave (sequencer).
// -----------------------------------------------------------------------------
interface morph_gene_sequencer_if #(
  parameter int GENES = 8
);
  localparam int IDX_W = (GENES > 1) ? $clog2(GENES) : 1;

  logic                  i_start;
  logic                  i_abort;
  logic [GENES*16-1:0]   i_chromosome;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_proc_clr;
  logic                  o_proc_ce;
  logic [8:0]            o_el;
  logic [2:0]            o_morph_op;
  logic                  o_morph_in_sel;
  logic [2:0]            o_logic_op;
  logic [IDX_W-1:0]      o_gene_idx;

  modport master (
    output i_start, i_abort, i_chromosome,
    input  o_busy, o_done, o_proc_clr, o_proc_ce, o_el, o_morph_op,
           o_morph_in_sel, o_logic_op, o_gene_idx
  );

  modport slave (
    input  i_start, i_abort, i_chromosome,
    output o_busy, o_done, o_proc_clr, o_proc_ce, o_el, o_morph_op,
           o_morph_in_sel, o_logic_op, o_gene_idx
  );

endinterface

// File: rtl/morph_gene_mux.sv
// -----------------------------------------------------------------------------
// morph_gene_mux
// Purely combinational gene selector: picks gene i_idx out of the packed shadow
// chromosome. Out-of-range indices yield 0.
//   i_shadow [GENES*GENE_W] : packed chromosome, gene g at [g*16 +: 16]
//   i_idx    [IDX_W]        : gene index
//   o_gene   [GENE_W]       : selected gene
// -----------------------------------------------------------------------------
module morph_gene_mux
  import morph_seq_pkg::*;
#(
  parameter int GENES = 8,
  parameter int IDX_W = 3
) (
  input  logic [GENES*GENE_W-1:0] i_shadow,
  input  logic [IDX_W-1:0]        i_idx,
  output logic [GENE_W-1:0]       o_gene
);

  // AND-OR select so a non-power-of-two GENES never reads past the shadow word
  always_comb begin
    o_gene = {GENE_W{1'b0}};
    for (int g = 0; g < GENES; g++) begin
      o_gene = o_gene | (i_shadow[g*GENE_W +: GENE_W] & {GENE_W{(i_idx == IDX_W'(g))}});
    end
  end

endmodule

// File: rtl/morph_gene_sequencer.sv
// -----------------------------------------------------------------------------
// morph_gene_sequencer
// Sequences a MorphologicProcessor through one chromosome of GENES genes:
// latches the chromosome on start, pulses proc_clr, then issues one gene per
// clock with proc_ce, and pulses done at the end. All outputs are registered.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : morph_gene_sequencer_if.slave (start/abort/chromosome in,
//          busy/done/proc_* /field outputs/gene_idx out)
// Optional build macro: MORPH_SEQ_EARLY_STOP_EN -- a gene whose logic_op equals
// STOP_CODE ends the run without being issued.
// -----------------------------------------------------------------------------
module morph_gene_sequencer
  import morph_seq_pkg::*;
#(
  parameter int GENES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  morph_gene_sequencer_if.slave   bus
);

  localparam int               IDX_W    = (GENES > 1) ? $clog2(GENES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GENES - 1);

  seq_state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]          r_gene_idx, w_idx_nxt;
  logic [GENES*GENE_W-1:0]   r_shadow, w_shadow_nxt;
  logic                      r_busy, r_done, r_clr, r_ce, r_stop;
  logic                      w_busy_nxt, w_done_nxt, w_clr_nxt, w_ce_nxt, w_stop_nxt, w_run_nxt;
  gene_t                     r_fields, w_fields_nxt;
  logic [GENE_W-1:0]         w_gene;
  gene_t                     w_gene_dec;
  logic                      w_is_stop;

  // Gene for the cycle being entered (index of the next state)
  morph_gene_mux #(.GENES(GENES), .IDX_W(IDX_W)) u_mux (
    .i_shadow (r_shadow),
    .i_idx    (w_idx_nxt),
    .o_gene   (w_gene)
  );

  assign w_gene_dec = decode_gene(w_gene);

`ifdef MORPH_SEQ_EARLY_STOP_EN
  assign w_is_stop = is_stop(w_gene_dec);
`else
  assign w_is_stop = 1'b0;
`endif

  // Next-state, gene index and shadow-latch logic
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_gene_idx;
    w_shadow_nxt = r_shadow;
    case (r_state)
      IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          w_state_nxt  = CLEAR;
          w_shadow_nxt = bus.i_chromosome;
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      CLEAR: begin
        w_idx_nxt = {IDX_W{1'b0}};
        if (bus.i_abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // r_stop marks a withheld STOP gene in the current cycle
        if (bus.i_abort) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = {IDX_W{1'b0}};
        end else if ((r_gene_idx == LAST_IDX) || r_stop) begin
          w_state_nxt = DONE;
          w_idx_nxt   = {IDX_W{1'b0}};
        end else begin
          w_state_nxt = RUN;
          w_idx_nxt   = r_gene_idx + IDX_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = {IDX_W{1'b0}};
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Output values for the state being entered; fields only move on an issued gene
  always_comb begin
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (w_state_nxt == DONE);
    w_clr_nxt  = (w_state_nxt == CLEAR);
    w_run_nxt  = (w_state_nxt == RUN);
    w_ce_nxt   = w_run_nxt && !w_is_stop;
    w_stop_nxt = w_run_nxt && w_is_stop;
    if (w_ce_nxt) begin
      w_fields_nxt = w_gene_dec;
    end else begin
      w_fields_nxt = r_fields;
    end
  end

  // State, index, shadow chromosome and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gene_idx <= {IDX_W{1'b0}};
      r_shadow   <= {(GENES*GENE_W){1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_clr      <= 1'b0;
      r_ce       <= 1'b0;
      r_stop     <= 1'b0;
      r_fields   <= gene_t'({GENE_W{1'b0}});
    end else begin
      r_state    <= w_state_nxt;
      r_gene_idx <= w_idx_nxt;
      r_shadow   <= w_shadow_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_clr      <= w_clr_nxt;
      r_ce       <= w_ce_nxt;
      r_stop     <= w_stop_nxt;
      r_fields   <= w_fields_nxt;
    end
  end

  assign bus.o_busy         = r_busy;
  assign bus.o_done         = r_done;
  assign bus.o_proc_clr     = r_clr;
  assign bus.o_proc_ce      = r_ce;
  assign bus.o_el           = r_fields.el;
  assign bus.o_morph_op     = r_fields.morph_op;
  assign bus.o_morph_in_sel = r_fields.morph_in_sel;
  assign bus.o_logic_op     = r_fields.logic_op;
  assign bus.o_gene_idx     = r_gene_idx;

endmodule
